// File: rtl/dvp_tx_pkg.sv
// Shared types and constants for the DVP camera transmitter.
// Optional colour-bar source is enabled by defining DVP_TX_PATTERN_EN.
package dvp_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } tx_state_e;

  localparam logic [15:0] RGB565_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB565_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB565_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB565_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB565_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB565_RED     = 16'hF800;
  localparam logic [15:0] RGB565_BLUE    = 16'h001F;
  localparam logic [15:0] RGB565_BLACK   = 16'h0000;

  // Clocks per line: two byte clocks per active pixel plus line blanking.
  function automatic int unsigned line_len(input int unsigned h_active,
                                           input int unsigned h_blank);
    return 2 * h_active + h_blank;
  endfunction

  // Colour of bar idx, left to right.
  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = RGB565_WHITE;
      3'd1:    c = RGB565_YELLOW;
      3'd2:    c = RGB565_CYAN;
      3'd3:    c = RGB565_GREEN;
      3'd4:    c = RGB565_MAGENTA;
      3'd5:    c = RGB565_RED;
      3'd6:    c = RGB565_BLUE;
      default: c = RGB565_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ov_cam_dvp_tx_if.sv
// RGB565 pixel stream (valid/ready) feeding the DVP transmitter.
interface ov_cam_dvp_tx_if;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        pix_ready;

  modport master (output pix_valid, output pix_data, input pix_ready);
  modport slave  (input pix_valid, input pix_data, output pix_ready);
endinterface

// File: rtl/dvp_tx_timing.sv
// Frame/line timing for the DVP transmitter: FSM plus h/v counters.
// Emits decoded per-clock markers that the top registers one clock later.
// pix_x_o exists only when DVP_TX_PATTERN_EN is defined.
module dvp_tx_timing
  import dvp_tx_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_BLANK  = 144,
  parameter int unsigned V_SYNC   = 3,
  parameter int unsigned V_BACK   = 17,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  localparam int unsigned PX_W    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tx_en_i,
  output logic vsync_pre_o,
  output logic href_pre_o,
  output logic odd_pre_o,
  output logic frame_start_pre_o,
  output logic frame_done_pre_o
`ifdef DVP_TX_PATTERN_EN
  ,output logic [PX_W-1:0] pix_x_o
`endif
);

  localparam int unsigned LINE_LEN = line_len(H_ACTIVE, H_BLANK);
  localparam int unsigned H_W      = $clog2(LINE_LEN);
  localparam int unsigned V_MAX0   = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
  localparam int unsigned V_MAX1   = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int unsigned V_MAX    = (V_MAX0 > V_MAX1) ? V_MAX0 : V_MAX1;
  localparam int unsigned V_W      = (V_MAX > 1) ? $clog2(V_MAX) : 1;

  localparam logic [H_W-1:0] H_LAST  = H_W'(LINE_LEN - 1);
  localparam logic [H_W:0]   HREF_END = (H_W+1)'(2 * H_ACTIVE);
  localparam logic [V_W-1:0] VS_LAST = V_W'((V_SYNC   > 0) ? V_SYNC   - 1 : 0);
  localparam logic [V_W-1:0] VB_LAST = V_W'((V_BACK   > 0) ? V_BACK   - 1 : 0);
  localparam logic [V_W-1:0] VA_LAST = V_W'((V_ACTIVE > 0) ? V_ACTIVE - 1 : 0);
  localparam logic [V_W-1:0] VF_LAST = V_W'((V_FRONT  > 0) ? V_FRONT  - 1 : 0);

  // First populated state of a frame; zero-line states are never entered.
  localparam tx_state_e START_ST = (V_SYNC != 0) ? ST_VSYNC :
                                   (V_BACK != 0) ? ST_VBACK : ST_ACTIVE;

  tx_state_e      state_q, state_nx;
  logic [H_W-1:0] h_cnt_q;
  logic [V_W-1:0] v_cnt_q;
  logic           sof_q;
  logic           line_end, v_last, frame_end;

  // Decode end-of-line / end-of-state and the state that follows the current one.
  always_comb begin
    v_last   = 1'b0;
    state_nx = ST_IDLE;
    line_end = (h_cnt_q == H_LAST);
    case (state_q)
      ST_VSYNC: begin
        v_last   = (v_cnt_q == VS_LAST);
        state_nx = (V_BACK != 0) ? ST_VBACK : ST_ACTIVE;
      end
      ST_VBACK: begin
        v_last   = (v_cnt_q == VB_LAST);
        state_nx = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        v_last   = (v_cnt_q == VA_LAST);
        state_nx = ST_VFRONT;
      end
      ST_VFRONT: begin
        v_last   = (v_cnt_q == VF_LAST);
        state_nx = ST_IDLE;
      end
      default: begin
        v_last   = 1'b0;
        state_nx = ST_IDLE;
      end
    endcase
    // With no front porch the frame ends on the last active line.
    frame_end = line_end && v_last &&
                ((state_q == ST_VFRONT) || ((state_q == ST_ACTIVE) && (V_FRONT == 0)));
  end

  // Frame FSM with h/v counters; tx_en only matters in IDLE and at frame end.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      sof_q   <= 1'b0;
    end else begin
      sof_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        h_cnt_q <= '0;
        v_cnt_q <= '0;
        if (tx_en_i) begin
          state_q <= START_ST;
          sof_q   <= 1'b1;
        end
      end else if (!line_end) begin
        h_cnt_q <= h_cnt_q + H_W'(1);
      end else begin
        h_cnt_q <= '0;
        if (!v_last) begin
          v_cnt_q <= v_cnt_q + V_W'(1);
        end else begin
          v_cnt_q <= '0;
          if (frame_end) begin
            if (tx_en_i) begin
              state_q <= START_ST;
              sof_q   <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            state_q <= state_nx;
          end
        end
      end
    end
  end

  assign vsync_pre_o       = (state_q == ST_VSYNC);
  assign href_pre_o        = (state_q == ST_ACTIVE) && ({1'b0, h_cnt_q} < HREF_END);
  assign odd_pre_o         = h_cnt_q[0];
  assign frame_start_pre_o = sof_q;
  assign frame_done_pre_o  = frame_end;
`ifdef DVP_TX_PATTERN_EN
  assign pix_x_o           = PX_W'(h_cnt_q >> 1);
`endif

endmodule

// File: rtl/ov_cam_dvp_tx.sv
// OmniVision-style DVP transmitter: RGB565 stream in, vsync/href/byte bus out,
// high byte first. One-entry pixel buffer, registered outputs.
// Define DVP_TX_PATTERN_EN to add tx_pattern and an 8-bar colour generator.
module ov_cam_dvp_tx
  import dvp_tx_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_BLANK  = 144,
  parameter int unsigned V_SYNC   = 3,
  parameter int unsigned V_BACK   = 17,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10
) (
  input  logic                 cmos_pclk,
  input  logic                 rst_n,
  input  logic                 tx_en,
`ifdef DVP_TX_PATTERN_EN
  input  logic                 tx_pattern,
`endif
  ov_cam_dvp_tx_if.slave       pix,
  output logic                 cmos_vsync,
  output logic                 cmos_href,
  output logic [7:0]           cmos_dout,
  output logic                 frame_start,
  output logic                 frame_done,
  output logic [7:0]           frame_cnt,
  output logic                 underrun
);

  localparam int unsigned PX_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

  logic        vsync_pre, href_pre, odd_pre, fs_pre, fd_pre;
  logic        even_slot, odd_slot, push, pop, use_pat;
  logic [15:0] pat_pix;
  logic [15:0] buf_q;
  logic        buf_full_q, hi_ok_q;
  logic [7:0]  dout_d;
  logic        underrun_d;
  logic        vsync_q, href_q, fs_q, fd_q, underrun_q;
  logic [7:0]  dout_q, frame_cnt_q;

`ifdef DVP_TX_PATTERN_EN
  logic [PX_W-1:0] pix_x;
  logic            pat_q;
`endif

  dvp_tx_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_BLANK  (H_BLANK),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK),
    .V_ACTIVE (V_ACTIVE),
    .V_FRONT  (V_FRONT)
  ) u_timing (
    .clk_i             (cmos_pclk),
    .rst_ni            (rst_n),
    .tx_en_i           (tx_en),
    .vsync_pre_o       (vsync_pre),
    .href_pre_o        (href_pre),
    .odd_pre_o         (odd_pre),
    .frame_start_pre_o (fs_pre),
    .frame_done_pre_o  (fd_pre)
`ifdef DVP_TX_PATTERN_EN
    ,.pix_x_o          (pix_x)
`endif
  );

`ifdef DVP_TX_PATTERN_EN
  // tx_pattern takes effect on the first clock of the frame, then is held.
  assign use_pat = fs_pre ? tx_pattern : pat_q;

  // Bar index = pixel_x * 8 / H_ACTIVE.
  always_comb begin
    pat_pix = bar_colour(3'((32'(pix_x) * 32'd8) / 32'(H_ACTIVE)));
  end

  // Latch the source selection for the whole frame.
  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q <= 1'b0;
    end else if (fs_pre) begin
      pat_q <= tx_pattern;
    end
  end
`else
  assign use_pat = 1'b0;
  assign pat_pix = '0;
`endif

  // An underrun pixel (hi_ok_q=0) is sent as zeros and never pops, so a pixel
  // arriving mid-slot waits for the next even clock.
  always_comb begin
    even_slot  = href_pre && !odd_pre;
    odd_slot   = href_pre && odd_pre;
    pop        = odd_slot && hi_ok_q && !use_pat;
    push       = pix.pix_valid && pix.pix_ready;
    dout_d     = '0;
    if (use_pat) begin
      if (href_pre) begin
        dout_d = odd_pre ? pat_pix[7:0] : pat_pix[15:8];
      end
    end else if (even_slot && buf_full_q) begin
      dout_d = buf_q[15:8];
    end else if (odd_slot && hi_ok_q) begin
      dout_d = buf_q[7:0];
    end
    underrun_d = underrun_q || (even_slot && !buf_full_q && !use_pat);
  end

  assign pix.pix_ready = !use_pat && (!buf_full_q || pop);

  // One-entry buffer; push with pop keeps it full with the new pixel.
  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      hi_ok_q    <= 1'b0;
    end else begin
      if (push) begin
        buf_q      <= pix.pix_data;
        buf_full_q <= 1'b1;
      end else if (pop) begin
        buf_full_q <= 1'b0;
      end
      if (even_slot) begin
        hi_ok_q <= buf_full_q && !use_pat;
      end
    end
  end

  // Output registers: everything lags the timing state by one clock.
  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      dout_q      <= '0;
      fs_q        <= 1'b0;
      fd_q        <= 1'b0;
      frame_cnt_q <= '0;
      underrun_q  <= 1'b0;
    end else begin
      vsync_q    <= vsync_pre;
      href_q     <= href_pre;
      dout_q     <= dout_d;
      fs_q       <= fs_pre;
      fd_q       <= fd_pre;
      underrun_q <= underrun_d;
      if (fd_pre) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end
  end

  assign cmos_vsync  = vsync_q;
  assign cmos_href   = href_q;
  assign cmos_dout   = dout_q;
  assign frame_start = fs_q;
  assign frame_done  = fd_q;
  assign frame_cnt   = frame_cnt_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_ov_cam_dvp_tx.sv
// Randomised bench for ov_cam_dvp_tx against a frame-position reference model.
module tb_ov_cam_dvp_tx;

  localparam int HA = 4, HB = 6, VS = 1, VB = 1, VA = 2, VF = 1;
  localparam int LINE  = 2 * HA + HB;
  localparam int FRAME = LINE * (VS + VB + VA + VF);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_en = 1'b0;
  logic       cmos_vsync, cmos_href, frame_start, frame_done, underrun;
  logic [7:0] cmos_dout, frame_cnt;

  ov_cam_dvp_tx_if pix_bus ();

  ov_cam_dvp_tx #(
    .H_ACTIVE (HA), .H_BLANK (HB), .V_SYNC (VS),
    .V_BACK   (VB), .V_ACTIVE (VA), .V_FRONT (VF)
  ) dut (
    .cmos_pclk   (clk),
    .rst_n       (rst_n),
    .tx_en       (tx_en),
`ifdef DVP_TX_PATTERN_EN
    .tx_pattern  (1'b0),
`endif
    .pix         (pix_bus),
    .cmos_vsync  (cmos_vsync),
    .cmos_href   (cmos_href),
    .cmos_dout   (cmos_dout),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: frame start edge, running flag, accepted-pixel FIFO with acceptance edge.
  int          edge_n = 0;
  bit          run = 0;
  int          s = 0;
  int          fcnt = 0;
  bit          urun = 0;
  logic [15:0] q_data[$];
  int          q_edge[$];
  logic [15:0] slot_pix = '0;
  bit          slot_ok = 0;
  bit          lo_pending = 0;
  bit          hs_pending = 0;
  int          src_mode = 0;
  int          stall_left = 0;
  int          seq = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge %0d: got %0h expected %0h", tag, edge_n, act, exp);
    end
  endtask

  task automatic chk_zero_outputs();
    chk("rst_vsync", 32'(cmos_vsync), 32'd0);
    chk("rst_href", 32'(cmos_href), 32'd0);
    chk("rst_dout", 32'(cmos_dout), 32'd0);
    chk("rst_fstart", 32'(frame_start), 32'd0);
    chk("rst_fdone", 32'(frame_done), 32'd0);
    chk("rst_fcnt", 32'(frame_cnt), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
  endtask

  task automatic tick();
    int p, ln, h, e_do;
    bit e_vs, e_hr, e_fs, e_fd, full_m, new_v;
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    if (!rst_n) begin
      run = 0; fcnt = 0; urun = 0; slot_ok = 0; lo_pending = 0; hs_pending = 0;
      q_data.delete(); q_edge.delete();
      chk_zero_outputs();
      chk("rst_ready", 32'(pix_bus.pix_ready), 32'd1);
      pix_bus.pix_valid = 1'b0;
    end else begin
      e_vs = 0; e_hr = 0; e_fs = 0; e_fd = 0; e_do = 0;
      if (run) begin
        p  = edge_n - 1 - s;
        ln = p / LINE;
        h  = p % LINE;
        e_vs = (ln < VS);
        e_fs = (p == 0);
        e_fd = (p == FRAME - 1);
        e_hr = (ln >= VS + VB) && (ln < VS + VB + VA) && (h < 2 * HA);
        if (e_hr && (h % 2 == 0)) begin
          if (q_edge.size() > 0 && q_edge[0] < edge_n) begin
            slot_pix = q_data.pop_front();
            void'(q_edge.pop_front());
            slot_ok = 1; lo_pending = 1;
            e_do = int'(slot_pix[15:8]);
          end else begin
            slot_ok = 0; urun = 1;
          end
        end else if (e_hr) begin
          e_do = slot_ok ? int'(slot_pix[7:0]) : 0;
          lo_pending = 0;
        end
        if (e_fd) fcnt = (fcnt + 1) % 256;
        if (p == FRAME - 1) begin
          if (tx_en) s = edge_n;
          else run = 0;
        end
      end else if (tx_en) begin
        run = 1;
        s = edge_n;
      end
      chk("vsync", 32'(cmos_vsync), 32'(e_vs));
      chk("href", 32'(cmos_href), 32'(e_hr));
      chk("dout", 32'(cmos_dout), 32'(e_do));
      chk("frame_start", 32'(frame_start), 32'(e_fs));
      chk("frame_done", 32'(frame_done), 32'(e_fd));
      chk("frame_cnt", 32'(frame_cnt), 32'(fcnt));
      chk("underrun", 32'(underrun), 32'(urun));
      full_m = (q_edge.size() > 0 && q_edge[0] <= edge_n) || lo_pending;
      chk("pix_ready", 32'(pix_bus.pix_ready), 32'(!full_m || lo_pending));

      // Pixel source: hold data until accepted.
      if (!pix_bus.pix_valid || hs_pending) begin
        case (src_mode)
          0:       new_v = 0;
          1:       new_v = 1;
          2:       new_v = (stall_left > 0);
          default: new_v = ($urandom_range(0, 1) == 1);
        endcase
        pix_bus.pix_valid = new_v;
        if (new_v) begin
          pix_bus.pix_data = (seq == 0) ? 16'h1234 :
                             (seq == 1) ? 16'h5678 : 16'($urandom_range(1, 65535));
          seq++;
          if (src_mode == 2) stall_left--;
        end
      end
      hs_pending = pix_bus.pix_valid && pix_bus.pix_ready;
      if (hs_pending) begin
        q_data.push_back(pix_bus.pix_data);
        q_edge.push_back(edge_n + 1);
      end
    end
  endtask

  initial begin
    pix_bus.pix_valid = 1'b0;
    pix_bus.pix_data  = '0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Idle after reset.
    repeat (50) tick();

    // Streaming frame with tx_en dropped mid-frame.
    src_mode = 1;
    tx_en = 1'b1;
    repeat (35) tick();
    tx_en = 1'b0;
    repeat (90) tick();

    // Source stalls after three pixels.
    src_mode = 2;
    stall_left = 3;
    tx_en = 1'b1;
    repeat (35) tick();
    tx_en = 1'b0;
    repeat (90) tick();

    // Back-to-back frames with a random source; frame_cnt wraps.
    src_mode = 3;
    tx_en = 1'b1;
    repeat (256 * FRAME + 10) tick();

    // Reset in the middle of an active line.
    for (int i = 0; i < 200; i++) begin
      if (run && ((edge_n - s) / LINE == VS + VB) && ((edge_n - s) % LINE == 3)) break;
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk_zero_outputs();
    repeat (3) tick();
    src_mode = 1;
    rst_n = 1'b1;
    repeat (FRAME + 5) tick();
    tx_en = 1'b0;
    repeat (90) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
